serializer8: RTL

SERIALIZER8 -- requirements
Module: serializer8

---
 rtl/serializer8_pkg.sv | 23 ++
 rtl/serializer8_if.sv | 32 +++
 rtl/serializer8_sel_counter.sv | 33 +++
 rtl/serializer8.sv | 117 +++++++++++
 4 files changed

// File: rtl/serializer8_pkg.sv
// Shared definitions for the 8-bit serializer: state enum, widths and
// helpers for the start/end positions of the bit index.
package serializer8_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Index of the first bit sent for the chosen bit order.
    function automatic logic [SEL_W-1:0] sel_start(input bit msb_first);
        return msb_first ? SEL_W'(WORD_W - 1) : '0;
    endfunction

    // Index of the last data bit sent for the chosen bit order.
    function automatic logic [SEL_W-1:0] sel_end(input bit msb_first);
        return msb_first ? '0 : SEL_W'(WORD_W - 1);
    endfunction

endpackage

// File: rtl/serializer8_if.sv
// Bus bundle between a word producer / bit consumer (master) and the
// serializer (slave).
//
// Handshake rules: a word moves when load_valid and load_ready are both 1
// at a rising edge; a bit moves when ser_valid and ser_ready are both 1 at
// a rising edge. load_valid/load_data may change freely while load_ready
// is 0, nothing is captured then. ser_out/sel/ser_last stay stable while
// ser_valid is 1 and ser_ready is 0.
interface serializer8_if;
    import serializer8_pkg::*;

    logic              load_valid;
    logic [WORD_W-1:0] load_data;
    logic              load_ready;
    logic              ser_ready;
    logic              ser_valid;
    logic              ser_out;
    logic              ser_last;
    logic [SEL_W-1:0]  sel;
    logic              busy;

    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, ser_valid, ser_out, ser_last, sel, busy
    );

    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, ser_valid, ser_out, ser_last, sel, busy
    );

endinterface

// File: rtl/serializer8_sel_counter.sv
// Bit index counter for the serializer: restarts at the order-dependent
// start index and steps up (LSB first) or down (MSB first).
module sel_counter
    import serializer8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_restart,
    input  logic             i_step,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_at_end
);

    localparam logic [SEL_W-1:0] START_SEL = sel_start(MSB_FIRST);
    localparam logic [SEL_W-1:0] END_SEL   = sel_end(MSB_FIRST);

    logic [SEL_W-1:0] r_sel;

    // Index register: reset and restart win over stepping.
    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_sel <= START_SEL;
        end else if (i_step) begin
            r_sel <= MSB_FIRST ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));
        end
    end

    assign o_sel    = r_sel;
    assign o_at_end = (r_sel == END_SEL);

endmodule

// File: rtl/serializer8.sv
// 8-bit parallel-to-serial converter with valid/ready on both sides.
// Optional macro SERIALIZER8_PARITY_EN appends an even-parity bit after the
// last data bit; without it words are exactly 8 bits.
module serializer8
    import serializer8_pkg::*;
#(
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    serializer8_if.slave   bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_data;

    logic             w_valid;
    logic             w_accept;
    logic             w_last;
    logic             w_word_done;
    logic             w_load_ready;
    logic             w_load;
    logic             w_restart;
    logic             w_step;
    logic             w_at_end;
    logic             w_ser_bit;
    logic [SEL_W-1:0] w_sel;

    assign w_valid  = (r_state == SHIFT);
    assign w_accept = w_valid & bus.ser_ready;

`ifdef SERIALIZER8_PARITY_EN
    logic r_par_phase;

    // Parity phase: entered when the last data bit is consumed, left when
    // the parity bit itself is consumed or the word is abandoned.
    always_ff @(posedge clk) begin
        if (rst || w_restart) begin
            r_par_phase <= 1'b0;
        end else if (w_accept && w_at_end) begin
            r_par_phase <= 1'b1;
        end
    end

    assign w_last    = w_valid & r_par_phase;
    assign w_ser_bit = r_par_phase ? (^r_data) : r_data[w_sel];
`else
    assign w_last    = w_valid & w_at_end;
    assign w_ser_bit = r_data[w_sel];
`endif

    assign w_word_done = w_accept & w_last;
    assign w_load      = bus.load_valid & w_load_ready;
    assign w_restart   = w_word_done | w_load;
    // Hold at the last data index so the parity bit (if any) reports it.
    assign w_step      = w_accept & ~w_at_end;

    // State register; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and load acceptance; a load on the final bit keeps SHIFT.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_load_ready = 1'b1;
                if (bus.load_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_load_ready = w_word_done;
                if (w_word_done && !bus.load_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Word register: captured only on an accepted load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= bus.load_data;
        end
    end

    sel_counter #(
        .MSB_FIRST (MSB_FIRST)
    ) u_sel_counter (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .i_step    (w_step),
        .o_sel     (w_sel),
        .o_at_end  (w_at_end)
    );

    assign bus.load_ready = w_load_ready;
    assign bus.ser_valid  = w_valid;
    assign bus.ser_out    = w_valid ? w_ser_bit : IDLE_LEVEL;
    assign bus.ser_last   = w_last;
    assign bus.sel        = w_sel;
    assign bus.busy       = w_valid;

endmodule
